// File: rtl/pipeline_step_ctrl_pkg.sv
// Shared types for the pipeline advance/flush controller.
// The debug unit decodes o_state with the same state encoding.
package pipeline_step_ctrl_pkg;

  localparam int BITS_REGS_DEF = 5;
  localparam int BITS_CNT_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef struct packed {
    logic step_pc;
    logic step_ifid;
    logic step_idex;
    logic step_exmem;
    logic step_memwb;
    logic flush_ifid;
    logic flush_idex;
  } ctl_t;

  function automatic logic is_adv_state(state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pipeline_step_ctrl_if.sv
// Bundle of debug-unit and pipeline-latch signals around the step controller.
// Signal names are from the controller's point of view (i_ into it, o_ out of it).
interface pipeline_step_ctrl_if #(
  parameter int BITS_REGS = 5,
  parameter int BITS_CNT  = 32
);
  logic                 i_run;
  logic                 i_step_req;
  logic                 i_resume;
  logic                 i_idex_mem_read;
  logic [BITS_REGS-1:0] i_idex_rt;
  logic [BITS_REGS-1:0] i_ifid_rs;
  logic [BITS_REGS-1:0] i_ifid_rt;
  logic                 i_ctrl_redirect;
  logic                 i_halt_wb;

  logic                 o_step_pc;
  logic                 o_step_ifid;
  logic                 o_step_idex;
  logic                 o_step_exmem;
  logic                 o_step_memwb;
  logic                 o_flush_ifid;
  logic                 o_flush_idex;
  logic [1:0]           o_state;
  logic                 o_busy;
  logic                 o_halted;
  logic [BITS_CNT-1:0]  o_cycle_cnt;

  modport master (
    output i_run, i_step_req, i_resume, i_idex_mem_read, i_idex_rt,
           i_ifid_rs, i_ifid_rt, i_ctrl_redirect, i_halt_wb,
    input  o_step_pc, o_step_ifid, o_step_idex, o_step_exmem, o_step_memwb,
           o_flush_ifid, o_flush_idex, o_state, o_busy, o_halted, o_cycle_cnt
  );

  modport slave (
    input  i_run, i_step_req, i_resume, i_idex_mem_read, i_idex_rt,
           i_ifid_rs, i_ifid_rt, i_ctrl_redirect, i_halt_wb,
    output o_step_pc, o_step_ifid, o_step_idex, o_step_exmem, o_step_memwb,
           o_flush_ifid, o_flush_idex, o_state, o_busy, o_halted, o_cycle_cnt
  );
endinterface

// File: rtl/pipeline_step_ctrl_hazard_detect.sv
// Combinational load-use detection and per-latch step/flush selection.
// Redirect wins over load-use: the stalled instruction is being squashed anyway.
module pipeline_step_ctrl_hazard_detect
  import pipeline_step_ctrl_pkg::*;
#(
  parameter int BITS_REGS = BITS_REGS_DEF
) (
  input  logic                 i_adv,
  input  logic                 i_idex_mem_read,
  input  logic [BITS_REGS-1:0] i_idex_rt,
  input  logic [BITS_REGS-1:0] i_ifid_rs,
  input  logic [BITS_REGS-1:0] i_ifid_rt,
  input  logic                 i_ctrl_redirect,
  output ctl_t                 o_ctl
);

  logic w_lu;

  assign w_lu = i_idex_mem_read && (i_idex_rt != '0) &&
                ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

  always_comb begin
    o_ctl = '0;
    if (i_adv) begin
      o_ctl.step_exmem = 1'b1;
      o_ctl.step_memwb = 1'b1;
      o_ctl.step_idex  = 1'b1;
      if (i_ctrl_redirect) begin
        o_ctl.step_pc    = 1'b1;
        o_ctl.step_ifid  = 1'b1;
        o_ctl.flush_ifid = 1'b1;
        o_ctl.flush_idex = 1'b1;
      end else if (w_lu) begin
        // hold PC and IF/ID, inject a bubble into ID/EX
        o_ctl.flush_idex = 1'b1;
      end else begin
        o_ctl.step_pc   = 1'b1;
        o_ctl.step_ifid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Pipeline advance/flush controller: run/step/halt FSM and advanced-cycle counter.
//   state     | meaning
//   ST_IDLE   | pipeline frozen, waiting for run or a step request
//   ST_RUN    | continuous advance while i_run stays high
//   ST_STEP   | single advance cycle, then back to idle
//   ST_HALTED | halt seen at MEM/WB, frozen until i_resume
module pipeline_step_ctrl
  import pipeline_step_ctrl_pkg::*;
#(
  parameter int BITS_REGS = BITS_REGS_DEF,
  parameter int BITS_CNT  = BITS_CNT_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  pipeline_step_ctrl_if.slave bus
);

  state_t              r_state;
  logic                r_busy;
  logic                r_halted;
  logic [BITS_CNT-1:0] r_cycle_cnt;
  logic                w_adv;
  ctl_t                w_ctl;

  // A halt at MEM/WB blocks the advance in the same cycle, so its write never lands.
  assign w_adv = is_adv_state(r_state) && !bus.i_halt_wb;

  pipeline_step_ctrl_hazard_detect #(
    .BITS_REGS (BITS_REGS)
  ) u_hazard_detect (
    .i_adv           (w_adv),
    .i_idex_mem_read (bus.i_idex_mem_read),
    .i_idex_rt       (bus.i_idex_rt),
    .i_ifid_rs       (bus.i_ifid_rs),
    .i_ifid_rt       (bus.i_ifid_rt),
    .i_ctrl_redirect (bus.i_ctrl_redirect),
    .o_ctl           (w_ctl)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_run) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else if (bus.i_step_req) begin
            r_state <= ST_STEP;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_halt_wb) begin
            r_state  <= ST_HALTED;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (!bus.i_run) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_STEP: begin
          r_busy <= 1'b0;
          if (bus.i_halt_wb) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          if (bus.i_resume) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cycle_cnt <= '0;
    end else if (w_adv) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign bus.o_step_pc    = w_ctl.step_pc;
  assign bus.o_step_ifid  = w_ctl.step_ifid;
  assign bus.o_step_idex  = w_ctl.step_idex;
  assign bus.o_step_exmem = w_ctl.step_exmem;
  assign bus.o_step_memwb = w_ctl.step_memwb;
  assign bus.o_flush_ifid = w_ctl.flush_ifid;
  assign bus.o_flush_idex = w_ctl.flush_idex;
  assign bus.o_state      = r_state;
  assign bus.o_busy       = r_busy;
  assign bus.o_halted     = r_halted;
  assign bus.o_cycle_cnt  = r_cycle_cnt;

endmodule
